mcpu_ctrl: RTL and testbench
============================

Name: mcpu_ctrl

Overview:
Multicycle MIPS control unit that sequences the mcpu datapath: drives the clock enables of the PC, IR and MDR registers, register-file and memory strobes, mux selects and ALU operation from a Moore FSM. Memory accesses stall on a `mem_ready` handshake. It sits beside the datapath and observes only opcode, funct and the ALU zero flag.

Parameters:
none (all encodings are fixed in the shared header)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, valid in BR state
mem_ready  in  1  memory completes the current access this cycle
pc_ce  out  1  PC register clock enable
ir_ce  out  1  IR register clock enable
mdr_ce  out  1  MDR register clock enable
reg_write  out  1  register-file write enable
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
iord  out  1  address select: 0 = PC, 1 = ALUOut
alu_src_a  out  2  ALU A select: 0 = PC, 1 = A, 2 = 0
alu_src_b  out  3  ALU B select: 0 = B, 1 = 4, 2 = sext(imm), 3 = sext(imm)<<2, 4 = zext(imm), 5 = imm<<16
alu_ctrl  out  3  ALU op: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB, 111 SLT
pc_source  out  2  PC input select: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = A
reg_dst  out  2  write register: 0 = rt, 1 = rd, 2 = 31
mem_to_reg  out  2  write data: 0 = ALUOut, 1 = MDR, 2 = PC
illegal  out  1  high while trapped on an undecodable instruction
state  out  4  current state, for debug and testbench

Behaviour:
- Reset and output model
  - `rst` high forces `state` to IF (0) asynchronously.
  - While `rst` is high, `pc_ce`, `ir_ce`, `mdr_ce`, `reg_write` and `mem_write` are forced to 0, and `illegal` is 0.
  - All other outputs are purely decoded from `state`. Unlisted outputs default to 0.
- States (4-bit encoding):
  - IF=0, ID=1, MEM_ADR=2, MEM_RD=3, LW_WB=4, MEM_WR=5, R_EX=6, R_WB=7, BR=8, J=9, I_EX=10, I_WB=11, JAL=12, JR=13, TRAP=14.
  - Code 15 is unreachable and decodes to TRAP.
- IF
  - `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, ADD, `pc_source`=0.
  - `ir_ce` = `pc_ce` = `mem_ready`.
  - Holds in IF while `mem_ready`=0; goes to ID when `mem_ready`=1.
- ID
  - `alu_src_a`=0, `alu_src_b`=3, ADD (branch target into ALUOut).
  - Next state by opcode:
    - 0x23 lw / 0x2B sw → MEM_ADR
    - 0x00 with funct 0x08 → JR
    - 0x00 with funct in {0x20, 0x22, 0x24, 0x25, 0x26, 0x27, 0x2A} → R_EX
    - 0x04 / 0x05 → BR
    - 0x02 → J
    - 0x03 → JAL
    - 0x08, 0x0A, 0x0C, 0x0D, 0x0E, 0x0F → I_EX
    - anything else → TRAP
- MEM_ADR: `alu_src_a`=1, `alu_src_b`=2, ADD; lw → MEM_RD, sw → MEM_WR.
- MEM_RD: `mem_read`=1, `iord`=1, `mdr_ce`=`mem_ready`; holds until `mem_ready`, then → LW_WB.
- LW_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1 → IF.
- MEM_WR: `mem_write`=1, `iord`=1; holds until `mem_ready`, then → IF.
- R_EX: `alu_src_a`=1, `alu_src_b`=0, `alu_ctrl` from funct (add→010, sub→110, and→000, or→001, xor→011, nor→100, slt→111) → R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0 → IF.
- I_EX: `alu_src_a`=1, except lui uses 2.
  - addi: `alu_src_b`=2, ADD
  - slti: `alu_src_b`=2, SLT
  - andi / ori / xori: `alu_src_b`=4, AND / OR / XOR
  - lui: `alu_src_b`=5, ADD
  - → I_WB
- I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 → IF.
- BR: `alu_src_a`=1, `alu_src_b`=0, SUB, `pc_source`=1; `pc_ce` = `zero` for beq, `~zero` for bne → IF.
- J: `pc_source`=2, `pc_ce`=1 → IF.
- JR: `pc_source`=3, `pc_ce`=1 → IF.
- JAL: `pc_source`=2, `pc_ce`=1, `reg_write`=1, `reg_dst`=2, `mem_to_reg`=2 → IF.
  - The register file captures the pre-update PC, which already holds PC+4.
- TRAP: `illegal`=1, all enables 0; only `rst` exits.
- Latency with `mem_ready` held at 1:
  - j / jal / jr / beq / bne: 3 cycles
  - R-type, I-type, sw: 4 cycles
  - lw: 5 cycles
  - Each cycle with `mem_ready`=0 in IF, MEM_RD or MEM_WR adds one cycle.
- `reg_write` and `mem_write` are never asserted in the same cycle.

Decomposition:
- Shared header mcpu_defs.vh: state codes, opcode/funct constants, alu_ctrl codes, all mux-select codes. The datapath includes the same header.
- One natural combinational sub-module, mcpu_alu_dec: (state, opcode, funct) → `alu_ctrl`.

Test Plan:
- `rst`=1 asserted mid-MEM_RD with `mem_ready`=0 → `state`=0 immediately, all enables 0 while `rst` is high; after release, IF with `mem_read`=1.
- add (opcode 0x00, funct 0x20), `mem_ready`=1 → `state` sequence 0,1,6,7,0; `alu_ctrl`=010 in R_EX; `reg_write`=1 and `reg_dst`=1 in cycle 4 only.
- lw (0x23), `mem_ready`=0 for 3 cycles in MEM_RD → MEM_RD held 4 cycles; `mdr_ce`=1 only in the ready cycle; 8 cycles total.
- beq (0x04) with `zero`=1 → `pc_ce`=1, `pc_source`=1 in BR; bne (0x05) with `zero`=1 → `pc_ce`=0.
- jal (0x03) → in JAL: `pc_ce`=1, `pc_source`=2, `reg_write`=1, `reg_dst`=2, `mem_to_reg`=2; back to IF next cycle.
- opcode 0x3F, or opcode 0x00 with funct 0x01 → TRAP (14), `illegal`=1 held for 20 cycles, no enables; `rst` returns to IF.

Source files
------------

// File: rtl/mcpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcode/funct
// constants, ALU operation codes and datapath mux selects.
package mcpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_LW_WB   = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EX    = 4'd6,
    S_R_WB    = 4'd7,
    S_BR      = 4'd8,
    S_J       = 4'd9,
    S_I_EX    = 4'd10,
    S_I_WB    = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13,
    S_TRAP    = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_A    = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [2:0] SRCB_B        = 3'd0;
  localparam logic [2:0] SRCB_FOUR     = 3'd1;
  localparam logic [2:0] SRCB_SEXT     = 3'd2;
  localparam logic [2:0] SRCB_SEXT_SH2 = 3'd3;
  localparam logic [2:0] SRCB_ZEXT     = 3'd4;
  localparam logic [2:0] SRCB_LUI      = 3'd5;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // Instruction class selected at the end of ID; anything undecodable traps.
  function automatic state_t decode_op(input logic [5:0] opcode, input logic [5:0] funct);
    state_t nxt;
    nxt = S_TRAP;
    case (opcode)
      OP_LW, OP_SW:   nxt = S_MEM_ADR;
      OP_BEQ, OP_BNE: nxt = S_BR;
      OP_J:           nxt = S_J;
      OP_JAL:         nxt = S_JAL;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: nxt = S_I_EX;
      OP_RTYPE: begin
        case (funct)
          FN_JR: nxt = S_JR;
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: nxt = S_R_EX;
          default: nxt = S_TRAP;
        endcase
      end
      default: nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mcpu_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, strobes and selects out.
interface mcpu_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_ce;
  logic       ir_ce;
  logic       mdr_ce;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [1:0] pc_source;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_ce, ir_ce, mdr_ce, reg_write, mem_read, mem_write, iord,
           alu_src_a, alu_src_b, alu_ctrl, pc_source, reg_dst, mem_to_reg,
           illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_ce, ir_ce, mdr_ce, reg_write, mem_read, mem_write, iord,
           alu_src_a, alu_src_b, alu_ctrl, pc_source, reg_dst, mem_to_reg,
           illegal, state
  );
endinterface

// File: rtl/mcpu_ctrl_alu_dec.sv
// ALU operation decoder: picks the ALU op from the current state and, in the
// execute states, from funct (R-type) or opcode (I-type).
module mcpu_ctrl_alu_dec
  import mcpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    // NOTE: default first so every path assigns alu_ctrl and no latch is inferred.
    alu_ctrl = ALU_AND;
    case (state)
      S_IF, S_ID, S_MEM_ADR: alu_ctrl = ALU_ADD;
      S_BR:                  alu_ctrl = ALU_SUB;
      S_R_EX: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_XOR:  alu_ctrl = ALU_XOR;
          FN_NOR:  alu_ctrl = ALU_NOR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      S_I_EX: begin
        case (opcode)
          OP_SLTI: alu_ctrl = ALU_SLT;
          OP_ANDI: alu_ctrl = ALU_AND;
          OP_ORI:  alu_ctrl = ALU_OR;
          OP_XORI: alu_ctrl = ALU_XOR;
          default: alu_ctrl = ALU_ADD;  // addi, lui
        endcase
      end
      default: alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch, decode, execute, memory and
// writeback for the mcpu datapath, stalling memory states on mem_ready.
module mcpu_ctrl
  import mcpu_ctrl_pkg::*;
(
  input logic         clk,
  input logic         rst,
  mcpu_ctrl_if.master bus
);

  state_t     state_q, state_d;
  logic       pc_ce, ir_ce, mdr_ce, reg_write, mem_write, illegal;
  logic       mem_read, iord;
  logic [1:0] alu_src_a, pc_source, reg_dst, mem_to_reg;
  logic [2:0] alu_src_b, alu_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_ce      = 1'b0;
    ir_ce      = 1'b0;
    mdr_ce     = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_B;
    pc_source  = PCSRC_ALU;
    reg_dst    = DST_RT;
    mem_to_reg = WB_ALUOUT;
    illegal    = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_ce     = bus.mem_ready;
        ir_ce     = bus.mem_ready;
        if (bus.mem_ready) state_d = S_ID;
      end
      S_ID: begin
        alu_src_b = SRCB_SEXT_SH2;
        state_d   = decode_op(bus.opcode, bus.funct);
      end
      S_MEM_ADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_SEXT;
        state_d   = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        mdr_ce   = bus.mem_ready;
        if (bus.mem_ready) state_d = S_LW_WB;
      end
      S_LW_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_MDR;
        state_d    = S_IF;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) state_d = S_IF;
      end
      S_R_EX: begin
        alu_src_a = SRCA_A;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = DST_RD;
        state_d   = S_IF;
      end
      S_I_EX: begin
        alu_src_a = (bus.opcode == OP_LUI) ? SRCA_ZERO : SRCA_A;
        case (bus.opcode)
          OP_ANDI, OP_ORI, OP_XORI: alu_src_b = SRCB_ZEXT;
          OP_LUI:                   alu_src_b = SRCB_LUI;
          default:                  alu_src_b = SRCB_SEXT;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_IF;
      end
      S_BR: begin
        alu_src_a = SRCA_A;
        pc_source = PCSRC_ALUOUT;
        pc_ce     = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
        state_d   = S_IF;
      end
      S_J: begin
        pc_source = PCSRC_JUMP;
        pc_ce     = 1'b1;
        state_d   = S_IF;
      end
      S_JR: begin
        pc_source = PCSRC_REG;
        pc_ce     = 1'b1;
        state_d   = S_IF;
      end
      S_JAL: begin
        // PC already holds PC+4 here, so the link value is the current PC.
        pc_source  = PCSRC_JUMP;
        pc_ce      = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = DST_RA;
        mem_to_reg = WB_PC;
        state_d    = S_IF;
      end
      default: begin  // S_TRAP and the unused code 15
        illegal = 1'b1;
        state_d = S_TRAP;
      end
    endcase
  end

  mcpu_ctrl_alu_dec u_alu_dec (
    .state    (state_q),
    .opcode   (bus.opcode),
    .funct    (bus.funct),
    .alu_ctrl (alu_ctrl)
  );

  // Enables are squashed during reset so no register updates while the FSM is held.
  assign bus.pc_ce      = pc_ce     & ~rst;
  assign bus.ir_ce      = ir_ce     & ~rst;
  assign bus.mdr_ce     = mdr_ce    & ~rst;
  assign bus.reg_write  = reg_write & ~rst;
  assign bus.mem_write  = mem_write & ~rst;
  assign bus.illegal    = illegal   & ~rst;
  assign bus.mem_read   = mem_read;
  assign bus.iord       = iord;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_ctrl   = alu_ctrl;
  assign bus.pc_source  = pc_source;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed bench for mcpu_ctrl: walks each instruction class through the FSM
// and checks states, strobes and selects against hand-computed values.
module tb_mcpu_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  mcpu_ctrl_if bus();

  mcpu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // {pc_ce, ir_ce, mdr_ce, reg_write, mem_write}
  function automatic logic [31:0] enables();
    return 32'({bus.pc_ce, bus.ir_ce, bus.mdr_ce, bus.reg_write, bus.mem_write});
  endfunction

  initial begin
    rst           = 1'b1;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset: IF, enables squashed even though mem_ready is high.
    #2;
    check("rst_state",   32'(bus.state), 0);
    check("rst_enables", enables(), 0);
    check("rst_illegal", 32'(bus.illegal), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("if_state",    32'(bus.state), 0);
    check("if_mem_read", 32'(bus.mem_read), 1);
    check("if_ir_ce",    32'(bus.ir_ce), 1);
    check("if_pc_ce",    32'(bus.pc_ce), 1);
    check("if_srcb",     32'(bus.alu_src_b), 1);
    check("if_alu",      32'(bus.alu_ctrl), 3'b010);

    // add: 0,1,6,7,0
    bus.opcode = 6'h00; bus.funct = 6'h20; cyc = 0;
    tick();
    check("add_id",        32'(bus.state), 1);
    check("add_id_srcb",   32'(bus.alu_src_b), 3);
    tick();
    check("add_rex",       32'(bus.state), 6);
    check("add_rex_alu",   32'(bus.alu_ctrl), 3'b010);
    check("add_rex_srca",  32'(bus.alu_src_a), 1);
    check("add_rex_srcb",  32'(bus.alu_src_b), 0);
    check("add_rex_rw",    32'(bus.reg_write), 0);
    tick();
    check("add_rwb",       32'(bus.state), 7);
    check("add_rwb_rw",    32'(bus.reg_write), 1);
    check("add_rwb_dst",   32'(bus.reg_dst), 1);
    check("add_rwb_m2r",   32'(bus.mem_to_reg), 0);
    tick();
    check("add_back_if",   32'(bus.state), 0);
    check("add_back_rw",   32'(bus.reg_write), 0);
    check("add_cycles",    32'(cyc), 4);

    // sub / nor ALU codes
    bus.funct = 6'h22;
    tick(); tick();
    check("sub_alu", 32'(bus.alu_ctrl), 3'b110);
    tick(); tick();
    bus.funct = 6'h27;
    tick(); tick();
    check("nor_alu", 32'(bus.alu_ctrl), 3'b100);
    tick(); tick();

    // lw with three stall cycles in MEM_RD: 8 cycles total
    bus.opcode = 6'h23; cyc = 0;
    tick();
    tick();
    check("lw_adr",      32'(bus.state), 2);
    check("lw_adr_srca", 32'(bus.alu_src_a), 1);
    check("lw_adr_srcb", 32'(bus.alu_src_b), 2);
    bus.mem_ready = 1'b0;
    tick();
    check("lw_rd1",      32'(bus.state), 3);
    check("lw_rd1_mdr",  32'(bus.mdr_ce), 0);
    check("lw_rd1_rd",   32'(bus.mem_read), 1);
    check("lw_rd1_iord", 32'(bus.iord), 1);
    tick();
    check("lw_rd2",      32'(bus.state), 3);
    check("lw_rd2_mdr",  32'(bus.mdr_ce), 0);
    tick();
    check("lw_rd3",      32'(bus.state), 3);
    check("lw_rd3_mdr",  32'(bus.mdr_ce), 0);
    tick();
    check("lw_rd4",      32'(bus.state), 3);
    bus.mem_ready = 1'b1;
    #1;
    check("lw_rd4_mdr",  32'(bus.mdr_ce), 1);
    tick();
    check("lw_wb",       32'(bus.state), 4);
    check("lw_wb_rw",    32'(bus.reg_write), 1);
    check("lw_wb_dst",   32'(bus.reg_dst), 0);
    check("lw_wb_m2r",   32'(bus.mem_to_reg), 1);
    tick();
    check("lw_back_if",  32'(bus.state), 0);
    check("lw_cycles",   32'(cyc), 8);

    // sw with one stall cycle
    bus.opcode = 6'h2B;
    tick(); tick();
    bus.mem_ready = 1'b0;
    tick();
    check("sw_wr",      32'(bus.state), 5);
    check("sw_wr_en",   enables(), 5'b00001);
    check("sw_wr_iord", 32'(bus.iord), 1);
    bus.mem_ready = 1'b1;
    tick();
    check("sw_back_if", 32'(bus.state), 0);

    // beq
    bus.opcode = 6'h04; bus.zero = 1'b1; cyc = 0;
    tick(); tick();
    check("beq_state",  32'(bus.state), 8);
    check("beq_pc_ce",  32'(bus.pc_ce), 1);
    check("beq_pcsrc",  32'(bus.pc_source), 1);
    check("beq_alu",    32'(bus.alu_ctrl), 3'b110);
    bus.zero = 1'b0;
    #1;
    check("beq_nz_pc_ce", 32'(bus.pc_ce), 0);
    tick();
    check("beq_back_if",  32'(bus.state), 0);
    check("beq_cycles",   32'(cyc), 3);

    // bne
    bus.opcode = 6'h05; bus.zero = 1'b1;
    tick(); tick();
    check("bne_z_pc_ce",  32'(bus.pc_ce), 0);
    bus.zero = 1'b0;
    #1;
    check("bne_nz_pc_ce", 32'(bus.pc_ce), 1);
    tick();

    // jal
    bus.opcode = 6'h03;
    tick(); tick();
    check("jal_state", 32'(bus.state), 12);
    check("jal_en",    enables(), 5'b10010);
    check("jal_pcsrc", 32'(bus.pc_source), 2);
    check("jal_dst",   32'(bus.reg_dst), 2);
    check("jal_m2r",   32'(bus.mem_to_reg), 2);
    tick();
    check("jal_back_if", 32'(bus.state), 0);

    // j and jr
    bus.opcode = 6'h02;
    tick(); tick();
    check("j_state", 32'(bus.state), 9);
    check("j_pcsrc", 32'(bus.pc_source), 2);
    check("j_en",    enables(), 5'b10000);
    tick();
    bus.opcode = 6'h00; bus.funct = 6'h08;
    tick(); tick();
    check("jr_state", 32'(bus.state), 13);
    check("jr_pcsrc", 32'(bus.pc_source), 3);
    check("jr_pc_ce", 32'(bus.pc_ce), 1);
    tick();

    // I-type: lui, ori, slti
    bus.opcode = 6'h0F;
    tick(); tick();
    check("lui_state", 32'(bus.state), 10);
    check("lui_srca",  32'(bus.alu_src_a), 2);
    check("lui_srcb",  32'(bus.alu_src_b), 5);
    check("lui_alu",   32'(bus.alu_ctrl), 3'b010);
    tick();
    check("lui_wb",     32'(bus.state), 11);
    check("lui_wb_rw",  32'(bus.reg_write), 1);
    check("lui_wb_dst", 32'(bus.reg_dst), 0);
    check("lui_wb_m2r", 32'(bus.mem_to_reg), 0);
    tick();
    bus.opcode = 6'h0D;
    tick(); tick();
    check("ori_srca", 32'(bus.alu_src_a), 1);
    check("ori_srcb", 32'(bus.alu_src_b), 4);
    check("ori_alu",  32'(bus.alu_ctrl), 3'b001);
    tick(); tick();
    bus.opcode = 6'h0A;
    tick(); tick();
    check("slti_srcb", 32'(bus.alu_src_b), 2);
    check("slti_alu",  32'(bus.alu_ctrl), 3'b111);
    tick(); tick();

    // Reset asserted mid-MEM_RD while stalled
    bus.opcode = 6'h23;
    tick(); tick();
    bus.mem_ready = 1'b0;
    tick();
    check("rrd_state", 32'(bus.state), 3);
    #2;
    rst = 1'b1;
    #1;
    check("rrd_async_state", 32'(bus.state), 0);
    check("rrd_enables",     enables(), 0);
    bus.mem_ready = 1'b1;
    #1;
    check("rrd_enables_rdy", enables(), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check("rrd_rel_state",    32'(bus.state), 0);
    check("rrd_rel_mem_read", 32'(bus.mem_read), 1);
    check("rrd_rel_ir_ce",    32'(bus.ir_ce), 0);
    tick();
    check("rrd_if_hold", 32'(bus.state), 0);
    bus.mem_ready = 1'b1;

    // Undecodable opcode 0x3F traps for good
    bus.opcode = 6'h3F;
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      check("trap_state",   32'(bus.state), 14);
      check("trap_illegal", 32'(bus.illegal), 1);
      check("trap_enables", enables(), 0);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    check("trap_rst_state",   32'(bus.state), 0);
    check("trap_rst_illegal", 32'(bus.illegal), 0);
    @(negedge clk);
    rst = 1'b0;

    // R-type with undefined funct traps too
    bus.opcode = 6'h00; bus.funct = 6'h01;
    tick(); tick();
    check("trap2_state",   32'(bus.state), 14);
    check("trap2_illegal", 32'(bus.illegal), 1);
    tick();
    check("trap2_hold",    32'(bus.state), 14);
    #2;
    rst = 1'b1;
    #1;
    check("trap2_rst_state", 32'(bus.state), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("trap2_rel_state", 32'(bus.state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
